// File: rtl/core_defs_pkg.sv
// Shared fetch-path definitions: default widths, reset/step constants and the queue entry type.
package core_defs_pkg;

  localparam int unsigned DefAddrW   = 32;
  localparam int unsigned DefInstW   = 32;
  localparam logic [31:0] DefResetPc = 32'h0000_0000;
  localparam int unsigned PcStep     = 4;
  localparam logic [31:0] NopInst    = 32'h0000_0000;

  typedef struct packed {
    logic [DefAddrW-1:0] pc;
    logic [DefInstW-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// Circular buffer of DEPTH entries; occupancy derives from pointers that carry an extra wrap bit.
module ifq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned PtrW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [PtrW:0]    count_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW:0]    wr_q, wr_d;
  logic [PtrW:0]    rd_q, rd_d;

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (flush_i) begin
      wr_d = '0;
      rd_d = '0;
    end else begin
      if (push_i) wr_d = wr_q + 1'b1;
      if (pop_i)  rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_q[PtrW-1:0]] <= data_i;
  end

  assign count_o = wr_q - rd_q;
  assign empty_o = (wr_q == rd_q);
  assign head_o  = mem_q[rd_q[PtrW-1:0]];

endmodule

// File: rtl/ifetch_queue.sv
// Sequential instruction fetch with a prefetch queue toward decode; redirect flushes everything.
module ifetch_queue import core_defs_pkg::*; #(
  parameter int unsigned        ADDR_W   = DefAddrW,
  parameter int unsigned        INST_W   = DefInstW,
  parameter int unsigned        DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = DefResetPc[ADDR_W-1:0],
  parameter int unsigned        PC_STEP  = PcStep,
  localparam int unsigned       CntW     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              o_rom_ce,
  output logic [ADDR_W-1:0] o_pc,
  input  logic [INST_W-1:0] i_inst,
  input  logic              i_stall,
  input  logic              i_redirect,
  input  logic [ADDR_W-1:0] i_redirect_pc,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_id_pc,
  output logic [INST_W-1:0] o_id_inst,
  output logic [CntW-1:0]   o_count
);

  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]        inflight_pc_q, inflight_pc_d;
  logic                     inflight_q, inflight_d;
  logic [CntW-1:0]          count;
  logic                     empty;
  logic [ADDR_W+INST_W-1:0] head;
  logic                     push, pop, issue;
  logic [CntW:0]            occ;

  always_comb begin
    pop  = ~empty & ~i_stall & ~i_redirect;
    push = inflight_q & ~i_redirect;
    // Reserve a slot for the outstanding response so the queue can never overflow.
    occ   = {1'b0, count} + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
    issue = ~i_redirect & (occ < (CntW+1)'(DEPTH));

    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (i_redirect) begin
      fetch_pc_d = i_redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  ifq_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ADDR_W + INST_W)
  ) u_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (push),
    .data_i ({inflight_pc_q, i_inst}),
    .pop_i  (pop),
    .flush_i(i_redirect),
    .count_o(count),
    .empty_o(empty),
    .head_o (head)
  );

  // Gate with reset so no request is visible while reset is held.
  assign o_rom_ce  = issue & rst;
  assign o_pc      = fetch_pc_q;
  assign o_valid   = ~empty;
  assign o_id_pc   = empty ? '0 : head[ADDR_W+INST_W-1:INST_W];
  assign o_id_inst = empty ? INST_W'(NopInst) : head[INST_W-1:0];
  assign o_count   = count;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: queue-based reference model checked every cycle plus directed literals.
module tb_ifetch_queue;

  logic        clk = 1'b0;
  logic        rst, rst_w;
  logic        stall, redir;
  logic [31:0] redir_pc;

  logic        rom_ce, valid;
  logic [31:0] pc, id_pc, id_inst, rom_q;
  logic [2:0]  count;

  logic        w_ce, w_valid;
  logic [31:0] w_pc, w_id_pc, w_id_inst, w_rom_q;
  logic [2:0]  w_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ifetch_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'h0000_0000), .PC_STEP(4)
  ) u_dut (
    .clk(clk), .rst(rst), .o_rom_ce(rom_ce), .o_pc(pc), .i_inst(rom_q),
    .i_stall(stall), .i_redirect(redir), .i_redirect_pc(redir_pc),
    .o_valid(valid), .o_id_pc(id_pc), .o_id_inst(id_inst), .o_count(count)
  );

  ifetch_queue #(
    .ADDR_W(32), .INST_W(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)
  ) u_wrap (
    .clk(clk), .rst(rst_w), .o_rom_ce(w_ce), .o_pc(w_pc), .i_inst(w_rom_q),
    .i_stall(1'b0), .i_redirect(1'b0), .i_redirect_pc(32'h0),
    .o_valid(w_valid), .o_id_pc(w_id_pc), .o_id_inst(w_id_inst), .o_count(w_count)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] p);
    return p ^ 32'h5A5A_0F0F;
  endfunction

  // ROMs answer whatever the DUT actually requested, one cycle later.
  always @(posedge clk) rom_q   <= rom_ce ? inst_of(pc)   : 32'hDEAD_BEEF;
  always @(posedge clk) w_rom_q <= w_ce   ? inst_of(w_pc) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: PCs held in the queue, one outstanding request, next fetch address.
  logic [31:0] mq[$];
  bit          m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_pc;

  initial begin
    mq.delete();
    m_infl = 0;
    m_infl_pc = 0;
    m_pc = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        m_infl = 0;
        m_pc   = 32'h0;
      end else begin
        int  pops;
        bit  iss;
        pops = (mq.size() > 0 && !stall && !redir) ? 1 : 0;
        iss  = !redir && (mq.size() + int'(m_infl) - pops < 4);
        if (redir) begin
          mq.delete();
          m_infl = 0;
          m_pc   = redir_pc;
        end else begin
          if (pops == 1) void'(mq.pop_front());
          if (m_infl) mq.push_back(m_infl_pc);
          m_infl    = iss;
          m_infl_pc = m_pc;
          if (iss) m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  initial begin
    forever begin
      int  pops;
      bit  exp_ce;
      @(negedge clk);
      pops   = (mq.size() > 0 && !stall && !redir) ? 1 : 0;
      exp_ce = rst && !redir && (mq.size() + int'(m_infl) - pops < 4);
      chk("cmp_rom_ce", {31'b0, rom_ce}, {31'b0, exp_ce});
      chk("cmp_pc", pc, m_pc);
      chk("cmp_valid", {31'b0, valid}, (mq.size() > 0) ? 32'd1 : 32'd0);
      chk("cmp_count", {29'b0, count}, mq.size());
      chk("cmp_id_pc", id_pc, (mq.size() > 0) ? mq[0] : 32'h0);
      chk("cmp_id_inst", id_inst, (mq.size() > 0) ? inst_of(mq[0]) : 32'h0);
    end
  end

  initial begin
    rst = 0; rst_w = 0; stall = 0; redir = 0; redir_pc = 0;
    step(2);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_rom_ce", {31'b0, rom_ce}, 32'd0);
    chk("rst_count", {29'b0, count}, 32'd0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_inst", id_inst, 32'h0);

    // Free run: one instruction per cycle, two-cycle fill latency.
    rst = 1;
    #1;
    chk("run_c0_ce", {31'b0, rom_ce}, 32'd1);
    chk("run_c0_pc", pc, 32'h0);
    step(1);
    chk("run_c1_pc", pc, 32'h4);
    chk("run_c1_valid", {31'b0, valid}, 32'd0);
    step(1);
    chk("run_c2_valid", {31'b0, valid}, 32'd1);
    chk("run_c2_id_pc", id_pc, 32'h0);
    chk("run_c2_count", {29'b0, count}, 32'd1);
    step(3);
    chk("run_c5_id_pc", id_pc, 32'hC);
    chk("run_c5_count", {29'b0, count}, 32'd1);

    // Stall from cycle 2 until the queue is full, then drain in order.
    rst = 0;
    step(1);
    rst = 1;
    step(2);
    stall = 1;
    step(3);
    chk("fill_count", {29'b0, count}, 32'd4);
    chk("fill_ce", {31'b0, rom_ce}, 32'd0);
    chk("fill_head", id_pc, 32'h0);
    chk("fill_pc", pc, 32'h10);
    stall = 0;
    #1;
    chk("drain_ce", {31'b0, rom_ce}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("drain_id_pc", id_pc, 32'(4 * i));
      chk("drain_valid", {31'b0, valid}, 32'd1);
      step(1);
    end
    // Continuous pop at the occupancy limit: one per cycle, strictly sequential.
    for (int i = 0; i < 10; i++) begin
      chk("stream_id_pc", id_pc, 32'(20 + 4 * i));
      chk("stream_ce", {31'b0, rom_ce}, 32'd1);
      chk("stream_count", {29'b0, count}, 32'd3);
      step(1);
    end

    // Redirect with three queued entries and one response outstanding.
    redir = 1;
    redir_pc = 32'h100;
    #1;
    chk("redir_ce_low", {31'b0, rom_ce}, 32'd0);
    step(1);
    redir = 0;
    #1;
    chk("redir_count", {29'b0, count}, 32'd0);
    chk("redir_valid", {31'b0, valid}, 32'd0);
    chk("redir_pc", pc, 32'h100);
    chk("redir_ce", {31'b0, rom_ce}, 32'd1);
    step(1);
    chk("redir_r2_valid", {31'b0, valid}, 32'd0);
    step(1);
    chk("redir_r3_valid", {31'b0, valid}, 32'd1);
    chk("redir_r3_id_pc", id_pc, 32'h100);
    chk("redir_r3_inst", id_inst, inst_of(32'h100));

    // Back-to-back redirects while stalled: the last target wins.
    stall = 1;
    redir = 1;
    redir_pc = 32'h200;
    step(1);
    redir_pc = 32'h300;
    step(1);
    redir = 0;
    stall = 0;
    #1;
    chk("b2b_pc", pc, 32'h300);
    chk("b2b_ce", {31'b0, rom_ce}, 32'd1);
    step(2);
    chk("b2b_id_pc", id_pc, 32'h300);
    step(3);

    // Asynchronous reset between edges.
    #1;
    rst = 0;
    #1;
    chk("async_valid", {31'b0, valid}, 32'd0);
    chk("async_ce", {31'b0, rom_ce}, 32'd0);
    chk("async_count", {29'b0, count}, 32'd0);
    chk("async_id_inst", id_inst, 32'h0);
    step(1);
    rst = 1;
    #1;
    chk("async_restart_pc", pc, 32'h0);
    chk("async_restart_ce", {31'b0, rom_ce}, 32'd1);
    step(4);

    // Address wrap on the second instance.
    rst_w = 1;
    #1;
    chk("wrap_c0_pc", w_pc, 32'hFFFF_FFF8);
    chk("wrap_c0_ce", {31'b0, w_ce}, 32'd1);
    step(1);
    chk("wrap_c1_pc", w_pc, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_c2_pc", w_pc, 32'h0);
    chk("wrap_c2_id_pc", w_id_pc, 32'hFFFF_FFF8);
    chk("wrap_c2_count", {29'b0, w_count}, 32'd1);
    step(1);
    chk("wrap_c3_id_pc", w_id_pc, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_c4_id_pc", w_id_pc, 32'h0);
    chk("wrap_c4_inst", w_id_inst, inst_of(32'h0));
    chk("wrap_c4_valid", {31'b0, w_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
